stevehoover_counter: RTL and testbench

- Tiny Tapeout user tile containing an 8-bit up/down counter.
- Supports synchronous clear, parallel load, and either wrap or saturate at the limits.
- A sticky overflow flag records wrap/saturate events.
- The output byte shows the raw count, a hex 7-segment digit (low or high nibble), or a status word, selected by dedicated inputs. Sits directly under the chip-level tile wrapper.

---
 rtl/stevehoover_counter.sv | 101 ++++++++++
 tb/tb_stevehoover_counter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/stevehoover_counter.sv
// Tiny Tapeout tile: 8-bit up/down counter with clear, load, wrap/saturate,
// sticky overflow flag and a selectable raw / 7-segment / status output byte.
module stevehoover_counter #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [WIDTH-1:0] cnt;
    logic             ovf;

    logic       en, down, load, clr, sat;
    logic [1:0] mode;
    logic       unused;

    assign en     = ui_in[0];
    assign down   = ui_in[1];
    assign load   = ui_in[2];
    assign clr    = ui_in[3];
    assign sat    = ui_in[4];
    assign mode   = ui_in[6:5];
    assign unused = ui_in[7];

    logic is_zero, is_max;
    assign is_zero = (cnt == '0);
    assign is_max  = (cnt == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (ena) begin
            if (clr) begin
                cnt <= '0;
                ovf <= 1'b0;
            end else if (load) begin
                cnt <= uio_in[WIDTH-1:0];
                ovf <= 1'b0;
            end else if (en && !down) begin
                if (!is_max) begin
                    cnt <= cnt + 1'b1;
                end else begin
                    ovf <= 1'b1;
                    if (!sat) cnt <= '0;
                end
            end else if (en && down) begin
                if (!is_zero) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    ovf <= 1'b1;
                    if (!sat) cnt <= '1;
                end
            end
        end
    end

    // Active-high segments, bit0 = a .. bit6 = g.
    function automatic logic [6:0] seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_comb begin
        uo_out = '0;
        case (mode)
            2'b00:   uo_out = cnt;
            2'b01:   uo_out = {ovf, seg(cnt[3:0])};
            2'b10:   uo_out = {ovf, seg(cnt[7:4])};
            default: uo_out = {4'b0000, ovf, sat, is_max, is_zero};
        endcase
    end

    assign uio_out = '0;
    assign uio_oe  = '0;

endmodule

// File: tb/tb_stevehoover_counter.sv
// Self-checking bench for stevehoover_counter: directed scenarios followed by
// randomized stimulus compared against a behavioural reference model.
module tb_stevehoover_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] ui_in = '0;
    logic [7:0] uio_in = '0;
    logic [7:0] uo_out, uio_out, uio_oe;

    int total = 0;
    int bad = 0;

    int m_cnt = 0;
    bit m_ovf = 1'b0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    stevehoover_counter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_out();
        logic [7:0] c;
        c = 8'(m_cnt);
        case (ui_in[6:5])
            2'b00:   return c;
            2'b01:   return {m_ovf, seg_tab[m_cnt % 16]};
            2'b10:   return {m_ovf, seg_tab[m_cnt / 16]};
            default: return {4'b0000, m_ovf, ui_in[4], m_cnt == 255, m_cnt == 0};
        endcase
    endfunction

    // One clock: model applies the rules with the inputs present at the edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n && ena) begin
            if (ui_in[3]) begin
                m_cnt = 0; m_ovf = 1'b0;
            end else if (ui_in[2]) begin
                m_cnt = int'(uio_in); m_ovf = 1'b0;
            end else if (ui_in[0] && !ui_in[1]) begin
                if (m_cnt == 255) begin
                    m_ovf = 1'b1;
                    if (!ui_in[4]) m_cnt = 0;
                end else m_cnt = m_cnt + 1;
            end else if (ui_in[0] && ui_in[1]) begin
                if (m_cnt == 0) begin
                    m_ovf = 1'b1;
                    if (!ui_in[4]) m_cnt = 255;
                end else m_cnt = m_cnt - 1;
            end
        end
        #1;
    endtask

    task automatic set_ui(input logic [7:0] v);
        ui_in = v;
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        check("reset_uo", uo_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        ena   = 1'b1;

        // Count up five
        ui_in = 8'h01;
        repeat (5) tick();
        check("count5", uo_out, 8'h05);
        check("uio_oe", uio_oe, 8'h00);
        check("uio_out", uio_out, 8'h00);

        // Load FE, wrap up
        ui_in = 8'h04; uio_in = 8'hFE;
        tick();
        ui_in = 8'h01;
        tick(); tick();
        check("wrap_cnt", uo_out, 8'h00);
        set_ui(8'h60);
        check("wrap_status", uo_out, 8'h09);

        // Saturate down
        ui_in = 8'h04; uio_in = 8'h01;
        tick();
        ui_in = 8'h13;
        repeat (3) tick();
        set_ui(8'h00);
        check("sat_cnt", uo_out, 8'h00);
        set_ui(8'h70);
        check("sat_status", uo_out, 8'h0D);

        // Priority
        ui_in = 8'h0D; uio_in = 8'hAA;
        tick();
        set_ui(8'h60);
        check("prio_clr", uo_out, 8'h01);
        ui_in = 8'h05;
        tick();
        set_ui(8'h00);
        check("prio_load", uo_out, 8'hAA);

        // 7-segment
        ui_in = 8'h04; uio_in = 8'h3C;
        tick();
        set_ui(8'h20);
        check("seg_lo", uo_out, 8'h39);
        set_ui(8'h40);
        check("seg_hi", uo_out, 8'h4F);
        ui_in = 8'h04; uio_in = 8'hFF;
        tick();
        ui_in = 8'h01;
        repeat (4) tick();
        set_ui(8'h20);
        check("seg_ovf", uo_out, 8'hCF);

        // Tile disable holds state
        ena = 1'b0;
        ui_in = 8'h01;
        repeat (4) tick();
        set_ui(8'h00);
        check("ena_hold", uo_out, 8'h03);
        ena = 1'b1;

        // Asynchronous reset between edges
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        m_cnt = 0; m_ovf = 1'b0;
        #1;
        check("async_rst", uo_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [7:0] v;
            r = $urandom_range(0, 99);
            v = 8'($urandom);
            if (r >= 3) v[3] = 1'b0;
            if (r >= 8) v[2] = 1'b0;
            if ($urandom_range(0, 9) < 8) v[0] = 1'b1;
            if (i % 400 < 200) v[1] = (i % 400 >= 100);
            ui_in  = v;
            uio_in = 8'($urandom);
            ena    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 499) == 0) begin
                @(posedge clk);
                #3;
                rst_n = 1'b0;
                m_cnt = 0; m_ovf = 1'b0;
                #1;
                check("rnd_async_rst", uo_out, model_out());
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                tick();
                check("rnd_uo", uo_out, model_out());
                ui_in[6:5] = 2'($urandom);
                #1;
                check("rnd_uo_mode", uo_out, model_out());
            end
            if (i % 500 == 0) begin
                check("rnd_uio_oe", uio_oe, 8'h00);
                check("rnd_uio_out", uio_out, 8'h00);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
